// File: rtl/save_point_array_if.sv
// Save-point bank bus: point positions, bullet, draw pixel and the status/sprite
// results returned to game control and the frame-buffer writer.
//   master : game side; drives positions, bullet and draw pixel, reads results
//   slave  : save_point_array; reads inputs, drives isSave, Save_address,
//            saved, hit, last_idx, points_left
interface save_point_array_if #(
  parameter int unsigned NUM_POINTS = 4
) ();
  logic [10*NUM_POINTS-1:0] Position_X;
  logic [10*NUM_POINTS-1:0] Position_Y;
  logic [9:0]               Bullet_X;
  logic [9:0]               Bullet_Y;
  logic                     Bullet_valid;
  logic [9:0]               DrawX_write;
  logic [9:0]               DrawY_write;
  logic                     isSave;
  logic [24:0]              Save_address;
  logic                     saved;
  logic                     hit;
  logic [3:0]               last_idx;
  logic [4:0]               points_left;

  modport master (
    output Position_X, Position_Y, Bullet_X, Bullet_Y, Bullet_valid,
           DrawX_write, DrawY_write,
    input  isSave, Save_address, saved, hit, last_idx, points_left
  );

  modport slave (
    input  Position_X, Position_Y, Bullet_X, Bullet_Y, Bullet_valid,
           DrawX_write, DrawY_write,
    output isSave, Save_address, saved, hit, last_idx, points_left
  );
endinterface

// File: rtl/save_point_array.sv
// Bank of NUM_POINTS save-point sprites. Each point is READY until shot, then
// flashes its hit image for FLASH_FRAMES frames and disappears (DONE).
// Optional macro SAVE_REARM_EN: DONE lasts REARM_FRAMES frames, then the point
// returns to READY; without it DONE holds until reset.
// Ports:
//   frame_clk : frame clock, all state changes on its rising edge
//   Reset_n   : synchronous active-low reset
//   bus       : save_point_array_if.slave (positions, bullet, draw pixel in;
//               isSave/Save_address draw path, saved/hit/last_idx/points_left out)
module save_point_array #(
  parameter int unsigned NUM_POINTS   = 4,
  parameter int unsigned SIZE         = 32,
  parameter int unsigned FLASH_FRAMES = 2,
  parameter int unsigned IDLE_BASE    = 241600,
  parameter int unsigned HIT_BASE     = 242624,
  parameter int unsigned REARM_FRAMES = 60
) (
  input  logic frame_clk,
  input  logic Reset_n,
  save_point_array_if.slave bus
);

  localparam int unsigned LOG2_SIZE = $clog2(SIZE);
  localparam int unsigned CNT_MAX   = (FLASH_FRAMES > REARM_FRAMES) ? FLASH_FRAMES : REARM_FRAMES;
  localparam int unsigned CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {READY, FLASH, DONE} state_t;

  state_t           state_q [NUM_POINTS];
  state_t           state_d [NUM_POINTS];
  logic [CNT_W-1:0] cnt_q   [NUM_POINTS];
  logic [CNT_W-1:0] cnt_d   [NUM_POINTS];
  logic [NUM_POINTS-1:0] take_hit;
  logic [NUM_POINTS-1:0] flash_d;
  logic [3:0]       last_idx_q, last_idx_d;
  logic             saved_q, hit_q;
  logic [9:0]       dx, dy;
  logic             is_save_c;
  logic [24:0]      address_c;
  logic [4:0]       points_left_c;

  // Span test with an 11-bit end coordinate so points near 1023 do not wrap.
  function automatic logic covers(input logic [9:0] origin, input logic [9:0] p);
    return (p >= origin) && ({1'b0, p} < (11'(origin) + 11'(SIZE)));
  endfunction

  // Per-point next state, counters, and lowest-index hit capture.
  always_comb begin
    take_hit   = '0;
    flash_d    = '0;
    last_idx_d = last_idx_q;
    for (int i = 0; i < int'(NUM_POINTS); i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        READY: begin
          if (bus.Bullet_valid &&
              covers(bus.Position_X[10*i +: 10], bus.Bullet_X) &&
              covers(bus.Position_Y[10*i +: 10], bus.Bullet_Y)) begin
            state_d[i]  = FLASH;
            cnt_d[i]    = CNT_W'(FLASH_FRAMES - 1);
            take_hit[i] = 1'b1;
          end
        end
        FLASH: begin
          if (cnt_q[i] == '0) begin
            state_d[i] = DONE;
`ifdef SAVE_REARM_EN
            cnt_d[i]   = CNT_W'(REARM_FRAMES - 1);
`endif
          end else begin
            cnt_d[i] = cnt_q[i] - 1'b1;
          end
        end
        DONE: begin
`ifdef SAVE_REARM_EN
          if (cnt_q[i] == '0) state_d[i] = READY;
          else                cnt_d[i]   = cnt_q[i] - 1'b1;
`endif
        end
        default: state_d[i] = READY;
      endcase
      flash_d[i] = (state_d[i] == FLASH);
    end
    for (int i = int'(NUM_POINTS) - 1; i >= 0; i--) begin
      if (take_hit[i]) last_idx_d = 4'(i);
    end
  end

  // State register; reset wins over any same-cycle hit.
  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < int'(NUM_POINTS); i++) begin
        state_q[i] <= READY;
        cnt_q[i]   <= '0;
      end
      saved_q    <= 1'b0;
      hit_q      <= 1'b0;
      last_idx_q <= 4'd0;
    end else begin
      for (int i = 0; i < int'(NUM_POINTS); i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      saved_q    <= |take_hit;
      hit_q      <= |flash_d;
      last_idx_q <= last_idx_d;
    end
  end

  // Draw path: lowest visible point containing the pixel picks the sprite address.
  always_comb begin
    is_save_c = 1'b0;
    address_c = '0;
    dx        = '0;
    dy        = '0;
    for (int i = int'(NUM_POINTS) - 1; i >= 0; i--) begin
      if (state_q[i] != DONE &&
          covers(bus.Position_X[10*i +: 10], bus.DrawX_write) &&
          covers(bus.Position_Y[10*i +: 10], bus.DrawY_write)) begin
        dx        = bus.DrawX_write - bus.Position_X[10*i +: 10];
        dy        = bus.DrawY_write - bus.Position_Y[10*i +: 10];
        is_save_c = 1'b1;
        address_c = ((state_q[i] == FLASH) ? 25'(HIT_BASE) : 25'(IDLE_BASE))
                    + 25'(dx) + (25'(dy) << LOG2_SIZE);
      end
    end
  end

  // Count of points still available to be shot.
  always_comb begin
    points_left_c = '0;
    for (int i = 0; i < int'(NUM_POINTS); i++) begin
      points_left_c = points_left_c + 5'(state_q[i] == READY);
    end
  end

  assign bus.isSave       = is_save_c;
  assign bus.Save_address = address_c;
  assign bus.saved        = saved_q;
  assign bus.hit          = hit_q;
  assign bus.last_idx     = last_idx_q;
  assign bus.points_left  = points_left_c;

endmodule
